// File: rtl/lstm_pkg.sv
// Shared types for the Q6.11 LSTM blocks.
//   WIDTH / FRAC : data word width and fraction bits of the signed Q6.11 format
//   q6_11_t      : one signed Q6.11 data word
//   lstm_sched_state_t : sequence scheduler FSM states
package lstm_pkg;

  localparam int WIDTH = 18;
  localparam int FRAC  = 11;

  typedef logic signed [17:0] q6_11_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } lstm_sched_state_t;

endpackage

// File: rtl/lstm_seq_scheduler.sv
// lstm_seq_scheduler
//   Time-multiplexes one stateless Q6.11 LSTM core over a runtime-length input
//   sequence. Owns the recurrent c/h registers, accepts x_t over a valid/ready
//   port, presents x/c_prev/h_prev to the core, captures the core's c_new/h_new
//   CORE_LAT cycles later and returns the final c/h over a valid/ready port.
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   start, seq_len, c0, h0   sequence request (sampled only when accepted in IDLE)
//   busy                     high in every state except IDLE
//   err_len                  1-cycle pulse on start with seq_len outside 1..MAX_STEPS
//   x_valid, x_data, x_ready input sample stream
//   step_idx                 0-based index of the current step
//   core_x/c_prev/h_prev     to the core (straight from registers)
//   core_c_new/h_new         from the core
//   res_valid, res_ready     result handshake
//   c_out, h_out             final state (straight from registers)
module lstm_seq_scheduler #(
  parameter int WIDTH     = lstm_pkg::WIDTH,
  parameter int FRAC      = lstm_pkg::FRAC,
  parameter int MAX_STEPS = 16,
  parameter int CORE_LAT  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [$clog2(MAX_STEPS+1)-1:0]       seq_len,
  input  logic signed [WIDTH-1:0]              c0,
  input  logic signed [WIDTH-1:0]              h0,
  output logic                                 busy,
  output logic                                 err_len,
  input  logic                                 x_valid,
  input  logic signed [WIDTH-1:0]              x_data,
  output logic                                 x_ready,
  output logic [$clog2(MAX_STEPS)-1:0]         step_idx,
  output logic signed [WIDTH-1:0]              core_x,
  output logic signed [WIDTH-1:0]              core_c_prev,
  output logic signed [WIDTH-1:0]              core_h_prev,
  input  logic signed [WIDTH-1:0]              core_c_new,
  input  logic signed [WIDTH-1:0]              core_h_new,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic signed [WIDTH-1:0]              c_out,
  output logic signed [WIDTH-1:0]              h_out
);
  import lstm_pkg::*;

  localparam int LEN_W  = $clog2(MAX_STEPS + 1);
  localparam int IDX_W  = $clog2(MAX_STEPS);
  localparam int WAIT_W = (CORE_LAT < 2) ? 1 : $clog2(CORE_LAT + 1);

  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_STEPS);
  localparam logic [WAIT_W-1:0] LAT_LOAD = WAIT_W'(CORE_LAT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  lstm_sched_state_t r_state, w_next;

  logic signed [WIDTH-1:0] r_x, r_c, r_h;
  logic [IDX_W-1:0]        r_step;
  logic [LEN_W-1:0]        r_len;
  logic [WAIT_W-1:0]       r_wait;
  logic                    r_err_len, r_x_ready, r_res_valid, r_busy;

  logic w_len_ok, w_accept, w_sample, w_settled, w_last;

  assign w_len_ok  = (seq_len != '0) && (seq_len <= MAX_LEN);
  assign w_accept  = (r_state == IDLE) && start && w_len_ok;
  assign w_sample  = (r_state == FETCH) && x_valid;
  assign w_settled = (r_state == EVAL) && (r_wait == WAIT_ONE);
  // len is at least 1 once accepted, so len-1 always fits the step index width.
  assign w_last    = (r_step == IDX_W'(r_len - LEN_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_accept)  w_next = FETCH;
      FETCH: if (x_valid)   w_next = EVAL;
      EVAL:  if (w_settled) w_next = w_last ? DONE : FETCH;
      DONE:  if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake/status flags are registered from the next state so every output
  // comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_ready   <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_x_ready   <= (w_next == FETCH);
      r_res_valid <= (w_next == DONE);
      r_busy      <= (w_next != IDLE);
      r_err_len   <= (r_state == IDLE) && start && !w_len_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_c    <= '0;
      r_h    <= '0;
      r_step <= '0;
      r_len  <= '0;
      r_wait <= '0;
    end else begin
      if (w_accept) begin
        r_c    <= c0;
        r_h    <= h0;
        r_len  <= seq_len;
        r_step <= '0;
      end
      if (w_sample) begin
        r_x    <= x_data;
        r_wait <= LAT_LOAD;
      end
      if (r_state == EVAL) begin
        r_wait <= r_wait - WAIT_ONE;
        if (w_settled) begin
          r_c <= core_c_new;
          r_h <= core_h_new;
          if (!w_last) r_step <= r_step + IDX_W'(1);
        end
      end
    end
  end

  assign busy        = r_busy;
  assign err_len     = r_err_len;
  assign x_ready     = r_x_ready;
  assign step_idx    = r_step;
  assign core_x      = r_x;
  assign core_c_prev = r_c;
  assign core_h_prev = r_h;
  assign res_valid   = r_res_valid;
  assign c_out       = r_c;
  assign h_out       = r_h;

endmodule

// File: tb/tb_lstm_seq_scheduler.sv
// Directed bench for lstm_seq_scheduler. The LSTM core is stood in for by a
// combinational model matching all-zero weights/biases: c_new = c_prev/2, and
// h_new is taken as c_new/4 so the h path is also observable.
module tb_lstm_seq_scheduler;
  localparam int WIDTH     = 18;
  localparam int MAX_STEPS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [4:0] seq_len = '0;
  logic signed [WIDTH-1:0] c0 = '0, h0 = '0;
  logic busy, err_len, x_ready, res_valid;
  logic x_valid = 1'b0, res_ready = 1'b0;
  logic signed [WIDTH-1:0] x_data = '0;
  logic [3:0] step_idx;
  logic signed [WIDTH-1:0] core_x, core_c_prev, core_h_prev;
  logic signed [WIDTH-1:0] core_c_new, core_h_new, c_out, h_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign core_c_new = core_c_prev >>> 1;
  assign core_h_new = core_c_new >>> 2;

  lstm_seq_scheduler #(.WIDTH(WIDTH), .FRAC(11), .MAX_STEPS(MAX_STEPS), .CORE_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seq_len(seq_len), .c0(c0), .h0(h0),
    .busy(busy), .err_len(err_len), .x_valid(x_valid), .x_data(x_data),
    .x_ready(x_ready), .step_idx(step_idx), .core_x(core_x),
    .core_c_prev(core_c_prev), .core_h_prev(core_h_prev),
    .core_c_new(core_c_new), .core_h_new(core_h_new),
    .res_valid(res_valid), .res_ready(res_ready), .c_out(c_out), .h_out(h_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [4:0] len, input logic signed [WIDTH-1:0] c, input logic signed [WIDTH-1:0] h);
    seq_len = len; c0 = c; h0 = h; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the start edge until res_valid; also counts x_ready cycles.
  task automatic wait_res(output int lat, output int xr);
    lat = 0;
    xr  = x_ready ? 1 : 0;
    while (!res_valid && lat < 60) begin
      tick();
      lat++;
      if (x_ready) xr++;
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int lat, xr, acc, stalls;
    logic signed [WIDTH-1:0] hold_x, hold_c;

    // 1: reset
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_core_x", core_x, 0);
    chk("rst_res_valid", res_valid, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("idle_busy", busy, 0);
    chk("idle_x_ready", x_ready, 0);

    // 2: three steps, no stall
    x_valid = 1'b1; x_data = 18'sd100;
    start_seq(5'd3, 18'sd2048, 18'sd0);
    chk("t2_busy", busy, 1);
    wait_res(lat, xr);
    chk("t2_latency", lat, 6);
    chk("t2_x_ready_cycles", xr, 3);
    chk("t2_c_out", c_out, 256);
    chk("t2_h_out", h_out, 64);
    chk("t2_step_idx", step_idx, 2);
    chk("t2_core_x", core_x, 100);
    release_result();
    chk("t2_res_drop", res_valid, 0);
    chk("t2_idle", busy, 0);

    // 3: four stall cycles before the second sample
    x_valid = 1'b1; x_data = 18'sd100;
    start_seq(5'd3, 18'sd2048, 18'sd0);
    lat = 0; acc = 0; stalls = 0; hold_x = '0; hold_c = '0;
    while (!res_valid && lat < 60) begin
      if (x_valid && x_ready) acc++;
      tick();
      lat++;
      if (stalls > 0 && stalls < 4) begin
        chk("t3_stall_core_x", core_x, hold_x);
        chk("t3_stall_core_c", core_c_prev, hold_c);
      end
      if (acc == 1 && x_ready && stalls < 4) begin
        if (stalls == 0) begin hold_x = core_x; hold_c = core_c_prev; end
        x_valid = 1'b0;
        stalls++;
      end else begin
        x_valid = 1'b1;
      end
      x_data = 18'(100 + 10 * acc);
    end
    chk("t3_latency", lat, 10);
    chk("t3_c_out", c_out, 256);
    chk("t3_core_x", core_x, 120);
    release_result();

    // 4: illegal lengths
    x_valid = 1'b1;
    start_seq(5'd0, 18'sd2048, 18'sd0);
    chk("t4_err_zero", err_len, 1);
    chk("t4_busy_zero", busy, 0);
    tick();
    chk("t4_err_pulse", err_len, 0);
    start_seq(5'd17, 18'sd2048, 18'sd0);
    chk("t4_err_big", err_len, 1);
    chk("t4_x_ready_big", x_ready, 0);
    tick();
    chk("t4_err_pulse2", err_len, 0);
    chk("t4_busy_big", busy, 0);

    // 5: result held while res_ready low; start ignored in DONE
    start_seq(5'd1, 18'sd2048, 18'sd0);
    wait_res(lat, xr);
    chk("t5_latency", lat, 2);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      seq_len = 5'd2; c0 = '0;
      tick();
      chk("t5_res_hold", res_valid, 1);
    end
    start = 1'b0;
    chk("t5_c_hold", c_out, 1024);
    chk("t5_h_hold", h_out, 256);
    start = 1'b1; res_ready = 1'b1;
    tick();
    start = 1'b0; res_ready = 1'b0;
    chk("t5_res_drop", res_valid, 0);
    chk("t5_idle", busy, 0);
    tick();
    chk("t5_start_ignored", busy, 0);

    // 6: reset during EVAL of step 1
    start_seq(5'd3, 18'sd2048, 18'sd0);
    tick(); tick(); tick();
    chk("t6_in_eval", x_ready, 0);
    chk("t6_step1", step_idx, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_c_out", c_out, 0);
    chk("t6_rst_step", step_idx, 0);
    chk("t6_rst_core_x", core_x, 0);
    #2;
    rst_n = 1'b1;
    tick();
    start_seq(5'd1, 18'sd2048, 18'sd0);
    wait_res(lat, xr);
    chk("t6_latency", lat, 2);
    chk("t6_c_out", c_out, 1024);
    release_result();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
